// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall sequencer: merges ID load-use hazards with EX multi-cycle ops
// into the per-stage stall bus, and keeps saturating stall performance counters.
module pipe_stall_ctrl #(
    parameter int unsigned STALL_W = 6,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned PERF_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               ex_mc_start,
    input  logic [CNT_W-1:0]   ex_mc_cycles,
    output logic [STALL_W-1:0] stall,
    output logic               mc_busy,
    output logic               mc_done,
    output logic [PERF_W-1:0]  perf_stall,
    output logic [PERF_W-1:0]  perf_lu
);

    localparam logic [STALL_W-1:0] LU_VEC = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] MC_VEC = STALL_W'(6'b001111);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] op_len;
    logic             mc_stall;
    logic             busy_raw;

    // A zero-length request still costs one stall cycle.
    assign op_len = (ex_mc_cycles == '0) ? CNT_W'(1) : ex_mc_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mc_stall   = 1'b0;
        busy_raw   = 1'b0;
        mc_done    = 1'b0;
        case (state)
            IDLE: begin
                if (ex_mc_start) begin
                    mc_stall = 1'b1;
                    busy_raw = 1'b1;
                    if (op_len == CNT_W'(1)) begin
                        state_next = DONE;
                    end else begin
                        cnt_next   = op_len - CNT_W'(1);
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                mc_stall = 1'b1;
                busy_raw = 1'b1;
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                mc_done    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Stall and busy are forced low while reset is asserted, even with live requests.
    always_comb begin
        stall   = '0;
        mc_busy = 1'b0;
        if (rst) begin
            stall   = (mc_stall ? MC_VEC : '0) | (stallreq_id ? LU_VEC : '0);
            mc_busy = busy_raw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall <= '0;
            perf_lu    <= '0;
        end else begin
            if (stall[0] && (perf_stall != '1)) begin
                perf_stall <= perf_stall + PERF_W'(1);
            end
            if (stallreq_id && !mc_stall && (perf_lu != '1)) begin
                perf_lu <= perf_lu + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed hazard scenarios plus random traffic,
// checked against a cycle-count model; a narrow-counter instance covers saturation.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic [5:0]  stall;
    logic        mc_busy;
    logic        mc_done;
    logic [31:0] perf_stall;
    logic [31:0] perf_lu;
    logic [5:0]  s_stall;
    logic        s_busy;
    logic        s_done;
    logic [1:0]  s_perf_stall;
    logic [1:0]  s_perf_lu;

    int checks = 0;
    int errors = 0;

    // Model: stall cycles still owed after this one, and a pending done cycle.
    int     m_rem;
    bit     m_done;
    longint m_ps, m_lu, n_ps, n_lu;

    always #5 clk = ~clk;

    pipe_stall_ctrl u_dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
        .ex_mc_cycles(ex_mc_cycles), .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done),
        .perf_stall(perf_stall), .perf_lu(perf_lu)
    );

    pipe_stall_ctrl #(.PERF_W(2)) u_sat (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
        .ex_mc_cycles(ex_mc_cycles), .stall(s_stall), .mc_busy(s_busy), .mc_done(s_done),
        .perf_stall(s_perf_stall), .perf_lu(s_perf_lu)
    );

    function automatic longint sat_inc(input longint v, input longint maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_rem = 0; m_done = 0; m_ps = 0; m_lu = 0; n_ps = 0; n_lu = 0;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic sid, input logic start, input logic [5:0] cyc);
        bit         mc_now;
        logic [5:0] exp_stall;
        int         n;
        stallreq_id  = sid;
        ex_mc_start  = start;
        ex_mc_cycles = cyc;
        #1;
        mc_now    = (m_rem > 0) || (!m_done && start);
        exp_stall = (mc_now ? 6'b001111 : 6'b000000) | (sid ? 6'b000111 : 6'b000000);
        chk("stall", 64'(stall), 64'(exp_stall));
        chk("mc_busy", 64'(mc_busy), 64'(mc_now));
        chk("mc_done", 64'(mc_done), 64'(m_done));
        chk("perf_stall", 64'(perf_stall), 64'(m_ps));
        chk("perf_lu", 64'(perf_lu), 64'(m_lu));
        chk("sat_perf_stall", 64'(s_perf_stall), 64'(n_ps));
        chk("sat_perf_lu", 64'(s_perf_lu), 64'(n_lu));
        @(posedge clk);
        if (exp_stall[0]) begin
            m_ps = sat_inc(m_ps, 64'hFFFF_FFFF);
            n_ps = sat_inc(n_ps, 3);
        end
        if (sid && !mc_now) begin
            m_lu = sat_inc(m_lu, 64'hFFFF_FFFF);
            n_lu = sat_inc(n_lu, 3);
        end
        if (m_done) begin
            m_done = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_done = 1;
        end else if (start) begin
            n     = (cyc == 0) ? 1 : int'(cyc);
            m_rem = n - 1;
            if (m_rem == 0) m_done = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 6'd0);
    endtask

    initial begin
        longint ps0;
        rst          = 1'b0;
        stallreq_id  = 1'b0;
        ex_mc_start  = 1'b0;
        ex_mc_cycles = 6'd0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_busy", 64'(mc_busy), 64'd0);
        chk("rst_done", 64'(mc_done), 64'd0);
        chk("rst_perf", 64'({perf_stall, perf_lu}), 64'd0);
        rst = 1'b1;
        idle(2);

        // Single load-use bubble.
        step(1'b1, 1'b0, 6'd0);
        idle(1);
        chk("lu_perf_lu", 64'(perf_lu), 64'd1);
        chk("lu_perf_stall", 64'(perf_stall), 64'd1);

        // N=4, then the edge lengths.
        step(1'b0, 1'b1, 6'd4);
        idle(6);
        step(1'b0, 1'b1, 6'd0);
        idle(3);
        step(1'b0, 1'b1, 6'd1);
        idle(3);
        ps0 = m_ps;
        step(1'b0, 1'b1, 6'd63);
        idle(64);
        chk("n63_delta", 64'(perf_stall) - 64'(ps0), 64'd63);

        // Load-use and a restart attempt while busy; start again in the done cycle.
        step(1'b0, 1'b1, 6'd5);
        step(1'b1, 1'b0, 6'd0);
        step(1'b1, 1'b1, 6'd9);
        step(1'b0, 1'b1, 6'd2);
        idle(1);
        step(1'b0, 1'b1, 6'd7);
        step(1'b0, 1'b1, 6'd3);
        idle(3);

        // Reset in the middle of an op: immediate clear, no done pulse afterwards.
        step(1'b0, 1'b1, 6'd10);
        idle(3);
        rst         = 1'b0;
        stallreq_id = 1'b1;
        #1;
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_busy", 64'(mc_busy), 64'd0);
        chk("midrst_done", 64'(mc_done), 64'd0);
        chk("midrst_perf", 64'({perf_stall, perf_lu}), 64'd0);
        model_clear();
        @(negedge clk);
        stallreq_id = 1'b0;
        rst         = 1'b1;
        idle(12);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                 6'($urandom_range(0, 7)));
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
